// File: rtl/datapath_pkg.sv
// Shared datapath definitions: architectural register numbers, default widths
// and the machine word type.
package datapath_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;
    localparam logic [4:0] REG_SP   = 5'd29;
    localparam logic [4:0] REG_RA   = 5'd31;

    typedef logic [31:0] word_t;

    localparam word_t SP_INIT_DEF = 32'h0000_03FC;

endpackage

// File: rtl/rf_read_port.sv
// One combinational register-file read port: address mux, register-0 force
// and optional same-cycle write forwarding.
module rf_read_port
    import datapath_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter bit BYPASS = 1'b1
) (
    input  logic [DATA_W-1:0] regs [1 << ADDR_W],
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] rd_data_s;

    // Register 0 wins over forwarding; wr_en is already qualified upstream.
    always_comb begin
        rd_data_s = '0;
        if (rd_addr == ZERO_A) begin
            rd_data_s = '0;
        end else if (BYPASS && wr_en && (wr_addr == rd_addr)) begin
            rd_data_s = wr_data;
        end else begin
            rd_data_s = regs[rd_addr];
        end
    end

    assign rd_data = rd_data_s;

endmodule

// File: rtl/reg_file_2r1w.sv
// 32-entry flop-based register file: two async read ports, one sync write
// port, a never-forwarded debug read port and a committed-write counter.
module reg_file_2r1w
    import datapath_pkg::*;
#(
    parameter int                DATA_W  = DATA_W_DEF,
    parameter int                ADDR_W  = ADDR_W_DEF,
    parameter bit                BYPASS  = 1'b1,
    parameter logic [DATA_W-1:0] SP_INIT = DATA_W'(SP_INIT_DEF)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] DbgReg,
    output logic [DATA_W-1:0] DbgData,
    output logic [15:0]       WriteCount
);

    localparam int                DEPTH  = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);
    localparam logic [ADDR_W-1:0] SP_A   = ADDR_W'(REG_SP);

    logic [DATA_W-1:0] regs_r [DEPTH];
    logic [15:0]       write_count_r;
    logic              wr_en_s;
    logic [DATA_W-1:0] dbg_data_s;

    // Reset also blocks forwarding so outputs show cleared contents at once.
    assign wr_en_s = RegWrite & Reset_n & (WriteReg != ZERO_A);

    // Register storage; entry 0 is never written so it stays zero.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_r[i] <= (i == int'(SP_A)) ? SP_INIT : '0;
            end
        end else if (wr_en_s) begin
            regs_r[WriteReg] <= WriteData;
        end
    end

    // Committed-write counter, wraps naturally at 16 bits.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            write_count_r <= 16'd0;
        end else if (wr_en_s) begin
            write_count_r <= write_count_r + 16'd1;
        end
    end

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port1 (
        .regs    (regs_r),
        .rd_addr (ReadReg1),
        .wr_en   (wr_en_s),
        .wr_addr (WriteReg),
        .wr_data (WriteData),
        .rd_data (ReadData1)
    );

    rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port2 (
        .regs    (regs_r),
        .rd_addr (ReadReg2),
        .wr_en   (wr_en_s),
        .wr_addr (WriteReg),
        .wr_data (WriteData),
        .rd_data (ReadData2)
    );

    // Debug view shows stored contents only.
    always_comb begin
        dbg_data_s = '0;
        if (DbgReg == ZERO_A) begin
            dbg_data_s = '0;
        end else begin
            dbg_data_s = regs_r[DbgReg];
        end
    end

    assign DbgData    = dbg_data_s;
    assign WriteCount = write_count_r;

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Scoreboard bench for reg_file_2r1w: a forwarding and a non-forwarding
// instance share stimulus and are checked against an array reference model.
module tb_reg_file_2r1w;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [4:0]  ReadReg1 = 5'd0, ReadReg2 = 5'd0, WriteReg = 5'd0, DbgReg = 5'd0;
    logic        RegWrite = 1'b0;
    logic [31:0] WriteData = 32'd0;
    logic [31:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
    logic [15:0] wc_b, wc_n;

    always #5 Clk = ~Clk;

    reg_file_2r1w #(.BYPASS(1'b1)) u_byp (
        .Clk(Clk), .Reset_n(Reset_n), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_b), .ReadData2(rd2_b), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .DbgReg(DbgReg), .DbgData(dbg_b), .WriteCount(wc_b)
    );

    reg_file_2r1w #(.BYPASS(1'b0)) u_nobyp (
        .Clk(Clk), .Reset_n(Reset_n), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(rd1_n), .ReadData2(rd2_n), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .DbgReg(DbgReg), .DbgData(dbg_n), .WriteCount(wc_n)
    );

    typedef struct {
        string       tag;
        logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n, dbg;
        logic [15:0] wc;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mem_m [32];
    logic [15:0] wc_m;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic cmp(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h required=%h", tag, fld, act, exp);
        end
    endtask

    // Monitor: outputs are stable by the falling edge of each stimulus cycle.
    always @(negedge Clk) begin
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            cmp(mon_e.tag, "rd1_byp", rd1_b, mon_e.rd1_b);
            cmp(mon_e.tag, "rd2_byp", rd2_b, mon_e.rd2_b);
            cmp(mon_e.tag, "rd1_nobyp", rd1_n, mon_e.rd1_n);
            cmp(mon_e.tag, "rd2_nobyp", rd2_n, mon_e.rd2_n);
            cmp(mon_e.tag, "dbg_byp", dbg_b, mon_e.dbg);
            cmp(mon_e.tag, "dbg_nobyp", dbg_n, mon_e.dbg);
            cmp(mon_e.tag, "wcount_byp", {16'd0, wc_b}, {16'd0, mon_e.wc});
            cmp(mon_e.tag, "wcount_nobyp", {16'd0, wc_n}, {16'd0, mon_e.wc});
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a, input bit fwd,
                                               input bit rst_n, input bit we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (fwd && rst_n && we && (wa != 5'd0) && (wa == a)) return wd;
        return mem_m[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem_m[i] = (i == 29) ? 32'h0000_03FC : 32'd0;
        wc_m = 16'd0;
    endtask

    // One cycle: drive just after the rising edge, queue expectation, then
    // let the model commit the write at the following rising edge.
    task automatic step(input bit rst_n, input bit we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] dr, input string tag);
        exp_t e;
        Reset_n = rst_n; RegWrite = we; WriteReg = wa; WriteData = wd;
        ReadReg1 = a1; ReadReg2 = a2; DbgReg = dr;
        if (!rst_n) model_reset();
        e.tag   = tag;
        e.rd1_b = model_read(a1, 1'b1, rst_n, we, wa, wd);
        e.rd2_b = model_read(a2, 1'b1, rst_n, we, wa, wd);
        e.rd1_n = model_read(a1, 1'b0, rst_n, we, wa, wd);
        e.rd2_n = model_read(a2, 1'b0, rst_n, we, wa, wd);
        e.dbg   = (dr == 5'd0) ? 32'd0 : mem_m[dr];
        e.wc    = wc_m;
        sb_q.push_back(e);
        @(posedge Clk);
        if (rst_n && we && (wa != 5'd0)) begin
            mem_m[wa] = wd;
            wc_m      = wc_m + 16'd1;
        end
        #1;
    endtask

    initial begin
        logic [4:0]  ra, a1, a2, dr;
        logic [31:0] rd;
        bit          rw;
        model_reset();
        @(posedge Clk); #1;
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd29, 5'd29, "reset_state");
        step(1'b1, 1'b1, 5'd5, 32'h0000_1234, 5'd5, 5'd29, 5'd5, "pre_write5");
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5, 5'd5, "pre_read5");

        // Reset mid-cycle while a write to reg 5 is pending.
        step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd29, 5'd5, "reset_mid");
        step(1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 5'd5, 5'd29, 5'd5, "reset_release");
        step(1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5, "reset_hold");

        step(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0, "r0_pre");
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0, "r0_post");

        step(1'b1, 1'b1, 5'd8, 32'h0000_00F0, 5'd8, 5'd9, 5'd8, "basic_w8");
        step(1'b1, 1'b1, 5'd9, 32'h0000_000F, 5'd8, 5'd9, 5'd9, "basic_w9");
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd8, 5'd9, 5'd8, "basic_rd");
        if ((rd1_b | rd2_b) !== 32'h0000_00FF) begin
            n_checks++; n_fail++;
            $display("FAIL or_unit actual=%h required=%h", rd1_b | rd2_b, 32'h0000_00FF);
        end else begin
            n_checks++;
        end

        step(1'b1, 1'b1, 5'd10, 32'h1111_1111, 5'd0, 5'd0, 5'd10, "byp_setup");
        step(1'b1, 1'b1, 5'd10, 32'h2222_2222, 5'd10, 5'd10, 5'd10, "byp_same");
        step(1'b1, 1'b0, 5'd10, 32'd0, 5'd10, 5'd10, 5'd10, "byp_after");

        // Counter wrap from a clean reset.
        step(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd29, 5'd1, "wrap_reset");
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b1, 5'd1, $urandom, 5'd1, 5'd2, 5'd1, "wrap");
        end
        step(1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd1, 5'd1, "wrap_done");

        for (int i = 0; i < 10000; i++) begin
            rw = 1'($urandom_range(0, 1));
            ra = 5'($urandom);
            rd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            dr = ($urandom_range(0, 3) == 0) ? ra : 5'($urandom);
            step(1'b1, rw, ra, rd, a1, a2, dr, "random");
        end

        @(negedge Clk); #1;
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
